core_mem_responder: RTL and testbench
=====================================

// Module: core_mem_responder
// PURPOSE
//  Memory-side responder for the core's req/grnt memory interface (instruction or data port).
//  Accepts handshaked read/write requests into a word-addressed on-chip array.
//  Returns read data in order, a fixed number of cycles after acceptance.
//  Serves as the fetch/LSU target in core-level simulation and small FPGA builds.
// PARAMETERS
//  MEM_DEPTH   1024  words in array; power of two, >=16
//  RD_LATENCY  1     cycles from read handshake to rvalid_o; legal 1..4
//  INIT_FILE   ""    $readmemh image loaded at elaboration; empty = contents X
// PORTS
//  clk_i     in   1   clock, rising edge
//  arst_ni   in   1   asynchronous reset, active low
//  req_i     in   1   request valid from initiator
//  grnt_o    out  1   request accepted this cycle (handshake = req_i & grnt_o)
//  addr_i    in   32  byte address; word index = addr_i[2 +: $clog2(MEM_DEPTH)]
//  ren_i     in   1   read request
//  wen_i     in   1   write request
//  wdata_i   in   32  write data
//  rdata_o   out  32  read data, meaningful only while rvalid_o=1
//  rvalid_o  out  1   read response valid (single-cycle pulse per read)
//  err_o     out  1   sticky protocol error flag
// BEHAVIOUR
//  Reset: grnt_o=0 while arst_ni=0; rvalid_o=0, rdata_o=32'h0, err_o=0; all in-flight reads dropped.
//    Array contents are not reset.
//  Grant: combinational, grnt_o = req_i & ~stall (stall is 0 unless the feature is enabled).
//    No dependence on ren_i or wen_i.
//  addr_i[1:0] ignored; address bits above the index are ignored (array aliases/wraps).
//  Write (wen_i=1, ren_i=0) on handshake: array written at that clock edge; no response generated.
//  Read (ren_i=1, wen_i=0) on handshake:
//    - rvalid_o=1 with data exactly RD_LATENCY cycles later.
//    - Back-to-back reads: one response per cycle, strictly in order.
//  Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
//    A read accepted in the same cycle as a write is impossible (single port).
//  ren_i=wen_i=1 on handshake: performed as write, no response, err_o set.
//  ren_i=wen_i=0 on handshake: no access, no response, err_o set.
//  err_o clears only on reset.
//  req_i=0: no state change; response pipeline keeps draining.
//  Response pipeline: RD_LATENCY-stage valid/data shift register.
//    - Array read occurs in stage 0.
//    - Later stages register the data.
//    - Never stalls; no ready on the response side.
// CONFIGURATION
//  Macro: CORE_MEM_RESP_STALL_EN
//  Defined:
//    - 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advances every cycle.
//    - stall = (lfsr[1:0]==2'b00), so grnt_o is withheld ~25% of request cycles.
//    - Initiator must hold req_i and its address/data stable until granted.
//    - Response timing after grant is unchanged.
//  Not defined:
//    - stall=0, grnt_o = req_i.
//    - No LFSR logic is instantiated.
// STRUCTURE
//  core_pkg additions:
//    - mem_req_t struct {addr, wdata, ren, wen}
//    - mem_rsp_t struct {rdata, rvalid}
//    - constants MEM_LFSR_SEED=8'hA5, MEM_RD_LAT_MAX=4
//  Sub-module core_mem_resp_pipe: parameterised latency shift register (valid+data), async reset.
//  Top level holds the array, grant/stall logic, error flag, and a read-enable into pipe stage 0.
// TESTING
//  1 Reset: deassert arst_ni mid-read (RD_LATENCY=2).
//    -> no rvalid_o after release; err_o=0; rdata_o=0.
//  2 Write 32'hCAFE_0001 to 0x10, then read 0x10 the next cycle.
//    -> grnt both cycles; rvalid_o=1 with rdata_o=32'hCAFE_0001 exactly RD_LATENCY cycles after the read.
//  3 Back-to-back reads of 0x0, 0x4, 0x8 (preloaded 1,2,3), RD_LATENCY=3.
//    -> rvalid_o high for 3 consecutive cycles, data 1,2,3 in order.
//  4 Address wrap, MEM_DEPTH=16: write 32'h55 to 0x40, read 0x00.
//    -> rdata_o=32'h55.
//  5 Illegal requests: ren_i=wen_i=1 to 0x8 with wdata 32'h77, then read 0x8.
//    -> err_o=1 and stays 1; only the explicit read produces rvalid_o; that read returns 32'h77.
//  6 With CORE_MEM_RESP_STALL_EN, hold req_i for 200 reads.
//    -> every grant produces exactly one rvalid_o RD_LATENCY later; grnt_o low on LFSR-predicted cycles.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core's req/grnt memory interface.
package core_pkg;

  localparam logic [7:0] MEM_LFSR_SEED  = 8'hA5;
  localparam int         MEM_RD_LAT_MAX = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rvalid;
  } mem_rsp_t;

endpackage

// File: rtl/core_mem_resp_pipe.sv
// Fixed-latency response shift register: valid and data advance together, never stall.
module core_mem_resp_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_data
);

  logic              vld_p  [STAGES];
  logic [DATA_W-1:0] data_p [STAGES];

  // Data only moves with its valid, so rsp_data holds the last response between reads.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_p[s]  <= 1'b0;
        data_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= push;
      if (push) data_p[0] <= push_data;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) data_p[s] <= data_p[s-1];
      end
    end
  end

  assign rsp_vld  = vld_p[STAGES-1];
  assign rsp_data = data_p[STAGES-1];

endmodule

// File: rtl/core_mem_responder.sv
// Word-addressed memory responder for the req/grnt interface, in-order fixed-latency reads.
// Optional random grant stalls when CORE_MEM_RESP_STALL_EN is defined.
module core_mem_responder
  import core_pkg::*;
#(
  parameter int    MEM_DEPTH  = 1024,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        req_i,
  output logic        grnt_o,
  input  logic [31:0] addr_i,
  input  logic        ren_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  mem_req_t          req;
  mem_rsp_t          rsp;
  logic [31:0]       mem [MEM_DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              stall;
  logic              hs;
  logic              wr_en;
  logic              rd_en;
  logic              unused_addr;

  assign req         = '{addr: addr_i, wdata: wdata_i, ren: ren_i, wen: wen_i};
  assign idx         = req.addr[2 +: IDX_W];
  assign unused_addr = ^{req.addr[1:0], req.addr[31:IDX_W+2]};

`ifdef CORE_MEM_RESP_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running regardless of req_i.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) lfsr <= MEM_LFSR_SEED;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign grnt_o = req_i & ~stall & arst_ni;
  assign hs     = grnt_o;
  // Both-set is treated as a write; a read is only a clean ren without wen.
  assign wr_en  = hs & req.wen;
  assign rd_en  = hs & req.ren & ~req.wen;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= req.wdata;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)                        err_o <= 1'b0;
    else if (hs && (req.ren == req.wen)) err_o <= 1'b1;
  end

  core_mem_resp_pipe #(
    .DATA_W (32),
    .STAGES (RD_LATENCY)
  ) u_pipe (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .push      (rd_en),
    .push_data (mem[idx]),
    .rsp_vld   (rsp.rvalid),
    .rsp_data  (rsp.rdata)
  );

  assign rvalid_o = rsp.rvalid;
  assign rdata_o  = rsp.rdata;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: per-cycle vector table, plus a stall/LFSR run
// when CORE_MEM_RESP_STALL_EN is defined.
module tb_core_mem_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk     = 1'b0;
  logic        arst_ni = 1'b0;
  logic        req     = 1'b0;
  logic        ren     = 1'b0;
  logic        wen     = 1'b0;
  logic [31:0] addr    = '0;
  logic [31:0] wdata   = '0;
  logic        grnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_mem_responder #(
    .MEM_DEPTH  (DEPTH),
    .RD_LATENCY (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk_i    (clk),
    .arst_ni  (arst_ni),
    .req_i    (req),
    .grnt_o   (grnt),
    .addr_i   (addr),
    .ren_i    (ren),
    .wen_i    (wen),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .rvalid_o (rvalid),
    .err_o    (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rq;
    bit          rn;
    bit          wn;
    logic [31:0] a;
    logic [31:0] d;
    bit          g;
    bit          v;
    logic [31:0] rd;
    bit          crd;
    bit          e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit rq, bit rn, bit wn, logic [31:0] a, logic [31:0] d,
                              bit g, bit v, logic [31:0] rd, bit crd, bit e);
    vec_t t;
    t.rst = rst; t.rq = rq; t.rn = rn; t.wn = wn; t.a = a; t.d = d;
    t.g = g; t.v = v; t.rd = rd; t.crd = crd; t.e = e;
    return t;
  endfunction

  function automatic vec_t wr(logic [31:0] a, logic [31:0] d, bit v, logic [31:0] rd, bit e);
    return mk(0, 1, 0, 1, a, d, 1, v, rd, v, e);
  endfunction

  function automatic vec_t rd_(logic [31:0] a, bit v, logic [31:0] rd, bit e);
    return mk(0, 1, 1, 0, a, 0, 1, v, rd, v, e);
  endfunction

  function automatic vec_t idl(bit v, logic [31:0] rd, bit e);
    return mk(0, 0, 0, 0, 0, 0, 0, v, rd, v, e);
  endfunction

`ifdef CORE_MEM_RESP_STALL_EN
  bit hist[$];

  task automatic run_stall();
    logic [7:0] lm;
    int grants = 0;
    int rsps   = 0;
    int cyc    = 0;
    bit expv;
    @(negedge clk); arst_ni = 1'b0;
    repeat (2) @(negedge clk);
    arst_ni = 1'b1; lm = 8'hA5;
    req = 1'b1; ren = 1'b1; wen = 1'b0; addr = '0;
    while (grants < 200 && cyc < 1000) begin
      #1;
      expv = (cyc >= LAT) ? hist[cyc-LAT] : 1'b0;
      chk($sformatf("stall c%0d grnt", cyc), grnt, (lm[1:0] != 2'b00));
      chk($sformatf("stall c%0d rvalid", cyc), rvalid, expv);
      if (rvalid) rsps++;
      hist.push_back(grnt);
      if (grnt) grants++;
      @(posedge clk);
      lm = {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};
      @(negedge clk);
      addr = grants * 4;
      cyc++;
    end
    req = 1'b0; ren = 1'b0;
    repeat (LAT + 2) begin
      #1;
      expv = (cyc >= LAT) ? hist[cyc-LAT] : 1'b0;
      chk($sformatf("drain c%0d rvalid", cyc), rvalid, expv);
      if (rvalid) rsps++;
      hist.push_back(1'b0);
      @(negedge clk);
      cyc++;
    end
    chk("stall grant count", grants, 200);
    chk("stall response count", rsps, 200);
  endtask
`endif

  initial begin
    req = 1'b1; ren = 1'b1;
    @(negedge clk); #1;
    chk("reset grnt", grnt, 1'b0);
    chk("reset rvalid", rvalid, 1'b0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset err", err, 1'b0);

`ifdef CORE_MEM_RESP_STALL_EN
    run_stall();
`else
    // RAW on 0x10
    tbl.push_back(wr(32'h10, 32'hCAFE_0001, 0, 0, 0));
    tbl.push_back(rd_(32'h10, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(idl(1, 32'hCAFE_0001, 0));
    // Back-to-back reads
    tbl.push_back(wr(32'h0, 32'h1, 0, 0, 0));
    tbl.push_back(wr(32'h4, 32'h2, 0, 0, 0));
    tbl.push_back(wr(32'h8, 32'h3, 0, 0, 0));
    tbl.push_back(rd_(32'h0, 0, 0, 0));
    tbl.push_back(rd_(32'h4, 0, 0, 0));
    tbl.push_back(rd_(32'h8, 0, 0, 0));
    tbl.push_back(idl(1, 32'h1, 0));
    tbl.push_back(idl(1, 32'h2, 0));
    tbl.push_back(idl(1, 32'h3, 0));
    tbl.push_back(idl(0, 0, 0));
    // Address wrap with 16 words
    tbl.push_back(wr(32'h40, 32'h55, 0, 0, 0));
    tbl.push_back(rd_(32'h00, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(idl(1, 32'h55, 0));
    // ren without req: no grant, no response
    tbl.push_back(mk(0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(idl(0, 0, 0));
    // Granted request with neither ren nor wen
    tbl.push_back(mk(0, 1, 0, 0, 32'h8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 1));
    // Reset while a read is in flight
    tbl.push_back(rd_(32'h10, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idl(0, 0, 0));
    // ren and wen together: write, error, no response
    tbl.push_back(mk(0, 1, 1, 1, 32'h8, 32'h77, 1, 0, 0, 0, 0));
    tbl.push_back(rd_(32'h8, 0, 0, 1));
    tbl.push_back(idl(0, 0, 1));
    tbl.push_back(idl(0, 0, 1));
    tbl.push_back(idl(1, 32'h77, 1));
    tbl.push_back(idl(0, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      arst_ni = !tbl[i].rst;
      req     = tbl[i].rq;
      ren     = tbl[i].rn;
      wen     = tbl[i].wn;
      addr    = tbl[i].a;
      wdata   = tbl[i].d;
      #1;
      chk($sformatf("row%0d grnt", i), grnt, tbl[i].g);
      chk($sformatf("row%0d rvalid", i), rvalid, tbl[i].v);
      chk($sformatf("row%0d err", i), err, tbl[i].e);
      if (tbl[i].crd) chk($sformatf("row%0d rdata", i), rdata, tbl[i].rd);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
